// File: rtl/dma_copy_if.sv
// Memory access types and the tinymemif bus shared by dma_copy and its memory.
// A master drives read/write requests; a slave returns rd_data and busy (stall).
package tinymem_pkg;
   typedef enum logic [1:0] {
      MEM_ACCESS_SIZE_BYTE = 2'd0,
      MEM_ACCESS_SIZE_HALF = 2'd1,
      MEM_ACCESS_SIZE_WORD = 2'd2
   } mem_access_size_t;
endpackage

interface tinymemif;
   import tinymem_pkg::*;
   logic [31:0]      rd_addr;
   mem_access_size_t rd_size;
   logic [31:0]      rd_data;
   logic [31:0]      wr_addr;
   mem_access_size_t wr_size;
   logic [31:0]      wr_data;
   logic             wr_enable;
   logic             busy;

   modport master (
      output rd_addr, rd_size, wr_addr, wr_size, wr_data, wr_enable,
      input  rd_data, busy
   );

   modport slave (
      input  rd_addr, rd_size, wr_addr, wr_size, wr_data, wr_enable,
      output rd_data, busy
   );
endinterface

// File: rtl/dma_copy.sv
// Word-by-word memory copy engine on tinymemif (READ then WRITE per word).
// Optional DMA_FILL_EN adds a fill mode that writes one latched word to every destination.
module dma_copy
   import tinymem_pkg::*;
#(
   parameter int COUNT_W = 16
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               start_i,
   input  logic [31:0]        src_addr_i,
   input  logic [31:0]        dst_addr_i,
   input  logic [COUNT_W-1:0] count_i,
`ifdef DMA_FILL_EN
   input  logic               fill_i,
   input  logic [31:0]        fill_data_i,
`endif
   output logic               busy_o,
   output logic               done_o,
   tinymemif.master           memif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [COUNT_W-1:0] CNT_ZERO = {COUNT_W{1'b0}};
   localparam logic [COUNT_W-1:0] CNT_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};

   state_t             state_r;
   logic [31:0]        src_ptr_r;
   logic [31:0]        dst_ptr_r;
   logic [COUNT_W-1:0] remaining_r;
   logic [31:0]        data_r;
   logic [31:0]        rd_addr_r;
   mem_access_size_t   rd_size_r;
   logic               wr_en_r;
   logic               busy_r;
   logic               done_r;
`ifdef DMA_FILL_EN
   logic               fill_mode_r;
`endif

   // Write address/data come straight from the dst pointer and data register.
   assign memif.rd_addr   = rd_addr_r;
   assign memif.rd_size   = rd_size_r;
   assign memif.wr_addr   = dst_ptr_r;
   assign memif.wr_size   = MEM_ACCESS_SIZE_WORD;
   assign memif.wr_data   = data_r;
   assign memif.wr_enable = wr_en_r;
   assign busy_o          = busy_r;
   assign done_o          = done_r;

   // Transfer FSM with all outputs registered alongside the state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r     <= IDLE;
         src_ptr_r   <= 32'h0000_0000;
         dst_ptr_r   <= 32'h0000_0000;
         remaining_r <= CNT_ZERO;
         data_r      <= 32'h0000_0000;
         rd_addr_r   <= 32'h0000_0000;
         rd_size_r   <= MEM_ACCESS_SIZE_WORD;
         wr_en_r     <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
`ifdef DMA_FILL_EN
         fill_mode_r <= 1'b0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (start_i) begin
                  src_ptr_r   <= {src_addr_i[31:2], 2'b00};
                  dst_ptr_r   <= {dst_addr_i[31:2], 2'b00};
                  remaining_r <= count_i;
                  busy_r      <= 1'b1;
                  if (count_i == CNT_ZERO) begin
                     done_r  <= 1'b1;
                     state_r <= DONE;
                  end
`ifdef DMA_FILL_EN
                  else if (fill_i) begin
                     data_r      <= fill_data_i;
                     fill_mode_r <= 1'b1;
                     wr_en_r     <= 1'b1;
                     state_r     <= WRITE;
                  end
`endif
                  else begin
`ifdef DMA_FILL_EN
                     fill_mode_r <= 1'b0;
`endif
                     rd_addr_r <= {src_addr_i[31:2], 2'b00};
                     rd_size_r <= MEM_ACCESS_SIZE_WORD;
                     state_r   <= READ;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end

            READ: begin
               rd_size_r <= MEM_ACCESS_SIZE_WORD;
               if (!memif.busy) begin
                  data_r  <= memif.rd_data;
                  wr_en_r <= 1'b1;
                  state_r <= WRITE;
               end else begin
                  state_r <= READ;
               end
            end

            // A stalled write keeps every write signal and pointer untouched.
            WRITE: begin
               if (!memif.busy) begin
                  src_ptr_r   <= src_ptr_r + 32'd4;
                  dst_ptr_r   <= dst_ptr_r + 32'd4;
                  remaining_r <= remaining_r - CNT_ONE;
                  if (remaining_r == CNT_ONE) begin
                     wr_en_r <= 1'b0;
                     done_r  <= 1'b1;
                     state_r <= DONE;
                  end
`ifdef DMA_FILL_EN
                  else if (fill_mode_r) begin
                     state_r <= WRITE;
                  end
`endif
                  else begin
                     wr_en_r   <= 1'b0;
                     rd_addr_r <= src_ptr_r + 32'd4;
                     state_r   <= READ;
                  end
               end else begin
                  state_r <= WRITE;
               end
            end

            DONE: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end

            default: begin
               wr_en_r <= 1'b0;
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule
